// File: rtl/txn_profiler.sv
// txn_profiler: observes the ap_ctrl handshake of a profiled module.
// It stamps each accepted start and pairs completions with starts oldest-first.
// Each completion yields a {rec_id, start_ts, latency} record.
// Records are queued toward a valid/ready consumer.
//
// Ports:
//   clock, reset         sole clock, asynchronous active-low reset
//   ap_start, ap_ready   start acceptance when both high (IDLE/RUN only)
//   ap_done, ap_continue completion when both high
//   finish               end-of-run request, moves the profiler into DRAIN
//   rec_ready            consumer accepts the current record
//   rec_valid, rec_id, rec_start_ts, rec_latency   registered record output
//   overflow             sticky, a start or a record was dropped
//   orphan_done          sticky, a completion had no matching start
//   all_done             drain complete, terminal until reset
module txn_profiler #(
    parameter int unsigned TS_W  = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_continue,
    input  logic              finish,
    input  logic              rec_ready,
    output logic              rec_valid,
    output logic [15:0]       rec_id,
    output logic [TS_W-1:0]   rec_start_ts,
    output logic [TS_W-1:0]   rec_latency,
    output logic              overflow,
    output logic              orphan_done,
    output logic              all_done
);

    localparam int unsigned ID_W  = 16;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REC_W = ID_W + 2 * TS_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_nx;
    logic [TS_W-1:0]    ts;
    logic [ID_W-1:0]    id_cnt;

    logic [TS_W-1:0]    sq_mem [DEPTH];
    logic [PTR_W-1:0]   sq_rd;
    logic [PTR_W-1:0]   sq_wr;
    logic [CNT_W-1:0]   sq_cnt;

    logic [REC_W-1:0]   rf_mem [DEPTH];
    logic [PTR_W-1:0]   rf_rd;
    logic [PTR_W-1:0]   rf_wr;
    logic [CNT_W-1:0]   rf_cnt;

    logic               start_acc, cmp, cmp_live, sq_empty, sq_full, sq_pop, sq_push;
    logic               bypass, start_drop, orphan_set, rec_gen, rec_pop;
    logic               rf_full, rf_push, rec_drop;
    logic [TS_W-1:0]    rec_sts, rec_lat;
    logic [REC_W-1:0]   rf_wdata, head_nx;
    logic [CNT_W-1:0]   sq_cnt_nx, rf_cnt_nx, rf_left;
    logic [PTR_W-1:0]   rf_rd_nx;

    // Event decode, queue bookkeeping and next state.
    always_comb begin
        start_acc  = ap_start & ap_ready & ~finish & ((state == IDLE) | (state == RUN));
        cmp        = ap_done & ap_continue;
        cmp_live   = cmp & (state != DONE);
        sq_empty   = (sq_cnt == '0);
        sq_full    = (sq_cnt == CNT_W'(DEPTH));
        sq_pop     = cmp_live & ~sq_empty;
        // Completion with nothing queued pairs with a same-cycle start.
        bypass     = cmp_live & sq_empty & start_acc;
        sq_push    = start_acc & ~bypass & (~sq_full | sq_pop);
        start_drop = start_acc & ~bypass & sq_full & ~sq_pop;
        orphan_set = cmp & ~sq_pop & ~bypass;
        rec_gen    = sq_pop | bypass;
        rec_sts    = sq_pop ? sq_mem[sq_rd] : ts;
        // Modular subtraction keeps the latency correct across ts wrap.
        rec_lat    = ts - rec_sts + TS_W'(1);
        rf_wdata   = {id_cnt, rec_sts, rec_lat};

        rf_full    = (rf_cnt == CNT_W'(DEPTH));
        rec_pop    = rec_valid & rec_ready;
        rf_push    = rec_gen & (~rf_full | rec_pop);
        rec_drop   = rec_gen & ~rf_push;

        sq_cnt_nx  = sq_cnt + CNT_W'(sq_push) - CNT_W'(sq_pop);
        rf_cnt_nx  = rf_cnt + CNT_W'(rf_push) - CNT_W'(rec_pop);
        rf_left    = rf_cnt - CNT_W'(rec_pop);
        rf_rd_nx   = rec_pop ? rf_rd + PTR_W'(1) : rf_rd;
        // Next head: fresh write when the FIFO would otherwise be empty.
        head_nx    = (rf_left == '0) ? rf_wdata : rf_mem[rf_rd_nx];

        state_nx = state;
        case (state)
            IDLE:    if (finish) state_nx = DRAIN;
                     else if (start_acc) state_nx = RUN;
            RUN:     if (finish) state_nx = DRAIN;
            DRAIN:   if (sq_empty && (rf_cnt == '0)) state_nx = DONE;
            default: state_nx = DONE;
        endcase
    end

    // Queue storage; contents are meaningless while the matching count is zero.
    always_ff @(posedge clock) begin
        if (sq_push) sq_mem[sq_wr] <= ts;
        if (rf_push) rf_mem[rf_wr] <= rf_wdata;
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ts           <= '0;
            id_cnt       <= '0;
            sq_rd        <= '0;
            sq_wr        <= '0;
            sq_cnt       <= '0;
            rf_rd        <= '0;
            rf_wr        <= '0;
            rf_cnt       <= '0;
            rec_valid    <= 1'b0;
            rec_id       <= '0;
            rec_start_ts <= '0;
            rec_latency  <= '0;
            overflow     <= 1'b0;
            orphan_done  <= 1'b0;
            all_done     <= 1'b0;
        end else begin
            state  <= state_nx;
            ts     <= ts + TS_W'(1);
            if (rec_gen) id_cnt <= id_cnt + ID_W'(1);
            if (sq_push) sq_wr <= sq_wr + PTR_W'(1);
            if (sq_pop)  sq_rd <= sq_rd + PTR_W'(1);
            sq_cnt <= sq_cnt_nx;
            if (rf_push) rf_wr <= rf_wr + PTR_W'(1);
            rf_rd  <= rf_rd_nx;
            rf_cnt <= rf_cnt_nx;
            rec_valid <= (rf_cnt_nx != '0);
            if (rf_cnt_nx != '0) {rec_id, rec_start_ts, rec_latency} <= head_nx;
            if (start_drop | rec_drop) overflow <= 1'b1;
            if (orphan_set) orphan_done <= 1'b1;
            all_done <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_txn_profiler.sv
// Directed bench for txn_profiler: default instance (TS_W=32, DEPTH=8) and a
// small instance (TS_W=8, DEPTH=2) for timestamp wrap and queue overflow.
module tb_txn_profiler;

    logic clock;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   ts_a   = 0;
    int   ts_b   = 0;

    // default instance
    logic a_reset, a_start, a_ready, a_done, a_cont, a_finish, a_rec_ready;
    logic a_rec_valid, a_overflow, a_orphan, a_all_done;
    logic [15:0] a_rec_id;
    logic [31:0] a_rec_sts, a_rec_lat;

    // small instance
    logic b_reset, b_start, b_ready, b_done, b_cont, b_finish, b_rec_ready;
    logic b_rec_valid, b_overflow, b_orphan, b_all_done;
    logic [15:0] b_rec_id;
    logic [7:0]  b_rec_sts, b_rec_lat;

    txn_profiler u_dut_a (
        .clock(clock), .reset(a_reset),
        .ap_start(a_start), .ap_ready(a_ready), .ap_done(a_done), .ap_continue(a_cont),
        .finish(a_finish), .rec_ready(a_rec_ready),
        .rec_valid(a_rec_valid), .rec_id(a_rec_id), .rec_start_ts(a_rec_sts),
        .rec_latency(a_rec_lat), .overflow(a_overflow), .orphan_done(a_orphan),
        .all_done(a_all_done)
    );

    txn_profiler #(.TS_W(8), .DEPTH(2)) u_dut_b (
        .clock(clock), .reset(b_reset),
        .ap_start(b_start), .ap_ready(b_ready), .ap_done(b_done), .ap_continue(b_cont),
        .finish(b_finish), .rec_ready(b_rec_ready),
        .rec_valid(b_rec_valid), .rec_id(b_rec_id), .rec_start_ts(b_rec_sts),
        .rec_latency(b_rec_lat), .overflow(b_overflow), .orphan_done(b_orphan),
        .all_done(b_all_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; samples and drives happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        ts_a = ts_a + 1;
        ts_b = (ts_b + 1) % 256;
    endtask

    task automatic reset_a();
        a_reset = 1'b0;
        #1;
        a_reset = 1'b1;
        ts_a = 0;
    endtask

    task automatic reset_b();
        b_reset = 1'b0;
        #1;
        b_reset = 1'b1;
        ts_b = 0;
    endtask

    task automatic check_rec_a(input string tag, input int id, input int sts, input int lat);
        check({tag, ".valid"}, 64'(a_rec_valid), 64'd1);
        check({tag, ".id"},    64'(a_rec_id),    64'(id));
        check({tag, ".sts"},   64'(a_rec_sts),   64'(sts));
        check({tag, ".lat"},   64'(a_rec_lat),   64'(lat));
    endtask

    task automatic check_rec_b(input string tag, input int id, input int sts, input int lat);
        check({tag, ".valid"}, 64'(b_rec_valid), 64'd1);
        check({tag, ".id"},    64'(b_rec_id),    64'(id));
        check({tag, ".sts"},   64'(b_rec_sts),   64'(sts));
        check({tag, ".lat"},   64'(b_rec_lat),   64'(lat));
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, ".valid"},  64'(a_rec_valid), 64'd0);
        check({tag, ".id"},     64'(a_rec_id),    64'd0);
        check({tag, ".sts"},    64'(a_rec_sts),   64'd0);
        check({tag, ".lat"},    64'(a_rec_lat),   64'd0);
        check({tag, ".ovf"},    64'(a_overflow),  64'd0);
        check({tag, ".orphan"}, 64'(a_orphan),    64'd0);
        check({tag, ".alldone"},64'(a_all_done),  64'd0);
    endtask

    initial begin
        a_reset = 1'b0; a_start = 0; a_ready = 0; a_done = 0; a_cont = 0; a_finish = 0; a_rec_ready = 0;
        b_reset = 1'b0; b_start = 0; b_ready = 0; b_done = 0; b_cont = 0; b_finish = 0; b_rec_ready = 0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_a("por_a");
        check("por_b.valid",   64'(b_rec_valid), 64'd0);
        check("por_b.alldone", 64'(b_all_done),  64'd0);
        a_reset = 1'b1; b_reset = 1'b1;
        ts_a = 0; ts_b = 0;

        // Single transaction: start at 5, done at 14, then finish held two cycles.
        a_rec_ready = 1'b1;
        while (ts_a < 5) tick();
        a_start = 1; a_ready = 1; tick(); a_start = 0; a_ready = 0;
        while (ts_a < 14) tick();
        a_done = 1; a_cont = 1; tick(); a_done = 0; a_cont = 0;
        check_rec_a("single", 0, 5, 10);
        tick();
        check("single.drained", 64'(a_rec_valid), 64'd0);
        a_finish = 1; tick(); tick(); a_finish = 0;
        begin
            int k = 0;
            while (!a_all_done && k < 10) begin tick(); k++; end
        end
        check("single.alldone", 64'(a_all_done), 64'd1);
        a_done = 1; a_cont = 1; tick(); a_done = 0; a_cont = 0;
        check("done_state.orphan", 64'(a_orphan),    64'd1);
        check("done_state.valid",  64'(a_rec_valid), 64'd0);
        check("done_state.ovf",    64'(a_overflow),  64'd0);

        // Bypass: start and done together with an empty start queue.
        reset_a();
        while (ts_a < 3) tick();
        a_start = 1; a_ready = 1; a_done = 1; a_cont = 1; tick();
        a_start = 0; a_ready = 0; a_done = 0; a_cont = 0;
        check_rec_a("bypass", 0, 3, 1);
        check("bypass.orphan", 64'(a_orphan), 64'd0);
        tick();
        a_done = 1; a_cont = 1; tick(); a_done = 0; a_cont = 0;
        check("bypass_nopush.orphan", 64'(a_orphan),    64'd1);
        check("bypass_nopush.valid",  64'(a_rec_valid), 64'd0);

        // Reset while a record is pending and two starts are outstanding.
        reset_a();
        a_rec_ready = 1'b0;
        while (ts_a < 1) tick();
        a_start = 1; a_ready = 1; tick(); tick(); tick(); a_start = 0; a_ready = 0;
        tick();
        a_done = 1; a_cont = 1; tick(); a_done = 0; a_cont = 0;
        check_rec_a("pre_reset", 0, 1, 5);
        a_reset = 1'b0;
        #1;
        check_reset_a("mid_reset");
        a_reset = 1'b1;
        ts_a = 0;
        while (ts_a < 3) tick();
        check("post_reset.valid", 64'(a_rec_valid), 64'd0);
        a_done = 1; a_cont = 1; tick(); a_done = 0; a_cont = 0;
        check("post_reset.orphan", 64'(a_orphan),    64'd1);
        check("post_reset.valid2", 64'(a_rec_valid), 64'd0);

        // Three back-to-back transactions with a stalled consumer.
        reset_a();
        a_rec_ready = 1'b0;
        while (ts_a < 2) tick();
        a_start = 1; a_ready = 1; repeat (3) tick(); a_start = 0; a_ready = 0;
        while (ts_a < 10) tick();
        a_done = 1; a_cont = 1; repeat (3) tick(); a_done = 0; a_cont = 0;
        check_rec_a("stall_early", 0, 2, 9);
        while (ts_a < 20) tick();
        check_rec_a("stall_mid", 0, 2, 9);
        while (ts_a < 30) tick();
        check_rec_a("stall_late", 0, 2, 9);
        a_rec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_rec_a($sformatf("burst%0d", i), i, 2 + i, 9);
            tick();
        end
        check("burst.empty", 64'(a_rec_valid), 64'd0);

        // Small instance: third start overflows a 2-deep queue.
        reset_b();
        b_rec_ready = 1'b1;
        while (ts_b < 1) tick();
        b_start = 1; b_ready = 1; repeat (3) tick(); b_start = 0; b_ready = 0;
        check("ovf.flag", 64'(b_overflow), 64'd1);
        while (ts_b < 10) tick();
        b_done = 1; b_cont = 1; tick(); b_done = 0; b_cont = 0;
        check_rec_b("ovf_rec0", 0, 1, 10);
        tick();
        check("ovf.taken0", 64'(b_rec_valid), 64'd0);
        b_done = 1; b_cont = 1; tick(); b_done = 0; b_cont = 0;
        check_rec_b("ovf_rec1", 1, 2, 11);
        check("ovf.orphan_before", 64'(b_orphan), 64'd0);
        tick();
        b_done = 1; b_cont = 1; tick(); b_done = 0; b_cont = 0;
        check("ovf.orphan", 64'(b_orphan),    64'd1);
        check("ovf.valid",  64'(b_rec_valid), 64'd0);

        // Small instance: latency across 8-bit timestamp wrap, then finish beats start.
        reset_b();
        b_rec_ready = 1'b1;
        while (ts_b != 250) tick();
        b_start = 1; b_ready = 1; tick(); b_start = 0; b_ready = 0;
        while (ts_b != 4) tick();
        b_done = 1; b_cont = 1; tick(); b_done = 0; b_cont = 0;
        check_rec_b("wrap", 0, 250, 11);
        tick();
        b_finish = 1; b_start = 1; b_ready = 1; tick();
        b_finish = 0; b_start = 0; b_ready = 0;
        begin
            int k = 0;
            while (!b_all_done && k < 10) begin tick(); k++; end
        end
        check("fin_prio.alldone", 64'(b_all_done),  64'd1);
        check("fin_prio.ovf",     64'(b_overflow),  64'd0);
        check("fin_prio.valid",   64'(b_rec_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/txn_profiler.md
TXN_PROFILER -- requirements
Module: txn_profiler

Interface
REQ-001 Parameter TS_W, default 32, timestamp/latency width in bits (8..32).
REQ-002 Parameter DEPTH, default 8, entries in each internal queue; power of 2, 2..64.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 ap_start, ap_ready, ap_done, ap_continue  in  1 each  observed ap_ctrl handshake of the profiled module.
REQ-007 finish  in  1  end-of-run request from the testbench.
REQ-008 rec_ready  in  1  downstream (CSV dumper) accepts a record.
REQ-009 rec_valid  out  1  record available.
REQ-010 rec_id  out  16  transaction index, 0-based, wraps at 65535->0.
REQ-011 rec_start_ts  out  TS_W  cycle stamp of start acceptance.
REQ-012 rec_latency  out  TS_W  cycles from start acceptance to done, inclusive.
REQ-013 overflow  out  1  sticky: a start or record was dropped.
REQ-014 orphan_done  out  1  sticky: done seen with no outstanding start.
REQ-015 all_done  out  1  drain complete, no further records.

Function
REQ-016 Free-running counter ts SHALL count from 0 after reset, +1 per cycle, wrap 2^TS_W-1 -> 0.
REQ-017 Start accepted in cycle where ap_start=1 and ap_ready=1 and state is IDLE or RUN; ts pushed into start queue (DEPTH deep).
REQ-018 Completion in cycle where ap_done=1 and ap_continue=1; pops oldest start entry present before that cycle.
REQ-019 Latency = (ts - start_ts + 1) mod 2^TS_W; wrap of ts SHALL NOT corrupt result.
REQ-020 Completion with empty start queue and simultaneous start acceptance: bypass, record start_ts=ts, latency=1, no queue push.
REQ-021 Completion with empty start queue, no simultaneous start: no record; orphan_done set.
REQ-022 Simultaneous push and pop on start queue SHALL both take effect, occupancy unchanged, also when full.
REQ-023 Start accepted while start queue full (and no pop same cycle): start dropped, overflow set.
REQ-024 Each completion SHALL push {rec_id, start_ts, latency} into record FIFO (DEPTH deep); rec_id increments per pushed record.
REQ-025 Record FIFO full at completion with no simultaneous pop: record dropped, overflow set, rec_id still increments.
REQ-026 Record interface is valid/ready: transfer when rec_valid & rec_ready; rec_valid, once high, SHALL stay high and outputs stable until transfer.
REQ-027 Record visible on rec_valid no earlier than the cycle after the completion (1-cycle minimum latency).
REQ-028 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-029 IDLE -> RUN on first accepted start; IDLE -> DRAIN on finish.
REQ-030 RUN -> DRAIN on finish=1; finish takes priority over start in same cycle (start ignored, not counted as dropped).
REQ-031 DRAIN: no new starts; completions still processed; DRAIN -> DONE when start queue empty, record FIFO empty, no transfer pending.
REQ-032 DONE: all_done=1, terminal until reset; completions set orphan_done only.
REQ-033 finish held high for multiple cycles SHALL have same effect as a one-cycle pulse.

Reset
REQ-034 reset low SHALL immediately clear: ts=0, both queues empty, rec_id counter=0, state=IDLE.
REQ-035 Output reset values: rec_valid=0, rec_id=0, rec_start_ts=0, rec_latency=0, overflow=0, orphan_done=0, all_done=0.
REQ-036 Reset asserted mid-transaction SHALL discard all in-flight starts and records; no record emitted for them after release.
REQ-037 First ts increment on first rising edge after reset deasserts.

Verification
REQ-038 Start accepted at ts=5, done at ts=14, rec_ready=1 -> one record id=0, start_ts=5, latency=10; all_done after finish.
REQ-039 Three starts at ts 2,3,4, dones at 10,11,12 -> ids 0,1,2, latencies 9,9,9 in order.
REQ-040 TS_W=8, start at ts=250, done at ts=4 (wrapped) -> latency 11.
REQ-041 DEPTH=2, three starts before any done -> overflow=1; two records emitted; third done sets orphan_done.
REQ-042 rec_ready=0 for 20 cycles with 3 completions (DEPTH=8) -> rec_valid held, payload stable, all 3 records delivered in order when rec_ready=1.
REQ-043 Reset pulse low while 2 starts outstanding -> all outputs at reset values; a later done yields orphan_done=1, no record.
